// File: rtl/spi_master.sv
// SPI master (mode 0, MSB first) with a small register-mapped bus slave.
// CTRL at offset 0x00 holds EN and DIV. STATUS at offset 0x04 holds BUSY, DONE and OVR.
// DATA at offset 0x08 starts a transfer on write and returns the received byte on read.
module spi_master (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        spi_clk,
  output logic        spi_ss,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  localparam logic [7:0] OFF_CTRL = 8'h00;
  localparam logic [7:0] OFF_STAT = 8'h04;
  localparam logic [7:0] OFF_DATA = 8'h08;

  state_t      state_r, state_s;
  logic        ctrl_en_r, ctrl_en_s;
  logic [7:0]  ctrl_div_r, ctrl_div_s;
  logic        done_r, done_s;
  logic        ovr_r, ovr_s;
  logic [7:0]  rx_byte_r, rx_byte_s;
  logic [7:0]  tx_shift_r, tx_shift_s;
  logic [7:0]  rx_shift_r, rx_shift_s;
  logic [7:0]  hcnt_r, hcnt_s;
  logic [3:0]  ecnt_r, ecnt_s;
  logic        sclk_r, sclk_s;
  logic        ss_r, ss_s;
  logic        mosi_r, mosi_s;

  logic [7:0]  offset_s;
  logic        wr_ctrl_s, wr_stat_s, wr_data_s;
  logic        busy_s, tick_s;
  logic        unused_s;

  assign offset_s  = addr_i[7:0];
  assign wr_ctrl_s = we_i && (offset_s == OFF_CTRL);
  assign wr_stat_s = we_i && (offset_s == OFF_STAT);
  assign wr_data_s = we_i && (offset_s == OFF_DATA);
  assign busy_s    = (state_r != ST_IDLE);
  // A half period ends when the down-counter reaches zero.
  assign tick_s    = (hcnt_r == 8'd0);
  assign unused_s  = ^{addr_i[31:8], data_i[31:16]};

  assign spi_clk  = sclk_r;
  assign spi_ss   = ss_r;
  assign spi_mosi = mosi_r;

  // Bus read mux, combinational from the address.
  always_comb begin
    data_o = 32'h0000_0000;
    case (offset_s)
      OFF_CTRL: data_o = {16'h0000, ctrl_div_r, 7'h00, ctrl_en_r};
      OFF_STAT: data_o = {29'h0000_0000, ovr_r, done_r, busy_s};
      OFF_DATA: data_o = {24'h00_0000, rx_byte_r};
      default:  data_o = 32'h0000_0000;
    endcase
  end

  // Next-state and next-output logic for the transfer FSM and the register file.
  always_comb begin
    state_s    = state_r;
    ctrl_en_s  = ctrl_en_r;
    ctrl_div_s = ctrl_div_r;
    done_s     = done_r;
    ovr_s      = ovr_r;
    rx_byte_s  = rx_byte_r;
    tx_shift_s = tx_shift_r;
    rx_shift_s = rx_shift_r;
    hcnt_s     = hcnt_r;
    ecnt_s     = ecnt_r;
    sclk_s     = sclk_r;
    ss_s       = ss_r;
    mosi_s     = mosi_r;

    // Clear the status bits first so that any set in the same cycle wins.
    if (wr_stat_s) begin
      if (data_i[1]) begin
        done_s = 1'b0;
      end else begin
        done_s = done_r;
      end
      if (data_i[2]) begin
        ovr_s = 1'b0;
      end else begin
        ovr_s = ovr_r;
      end
    end else begin
      done_s = done_r;
      ovr_s  = ovr_r;
    end

    if (wr_ctrl_s) begin
      ctrl_en_s  = data_i[0];
      ctrl_div_s = data_i[15:8];
    end else begin
      ctrl_en_s  = ctrl_en_r;
      ctrl_div_s = ctrl_div_r;
    end

    case (state_r)
      ST_IDLE: begin
        if (wr_data_s && ctrl_en_r) begin
          state_s    = ST_SETUP;
          tx_shift_s = data_i[7:0];
          hcnt_s     = ctrl_div_r;
          ecnt_s     = 4'd0;
          ss_s       = 1'b0;
          sclk_s     = 1'b0;
          mosi_s     = data_i[7];
          done_s     = 1'b0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (tick_s) begin
          state_s = ST_SHIFT;
          hcnt_s  = ctrl_div_r;
        end else begin
          hcnt_s = hcnt_r - 8'd1;
        end
      end
      ST_SHIFT: begin
        if (tick_s) begin
          hcnt_s = ctrl_div_r;
          sclk_s = ~sclk_r;
          ecnt_s = ecnt_r + 4'd1;
          if (!sclk_r) begin
            // Rising edge: sample the slave.
            rx_shift_s = {rx_shift_r[6:0], spi_miso};
          end else if (ecnt_r != 4'd15) begin
            // Falling edge: present the next bit.
            tx_shift_s = {tx_shift_r[6:0], 1'b0};
            mosi_s     = tx_shift_r[6];
          end else begin
            tx_shift_s = tx_shift_r;
          end
          if (ecnt_r == 4'd15) begin
            state_s = ST_HOLD;
          end else begin
            state_s = ST_SHIFT;
          end
        end else begin
          hcnt_s = hcnt_r - 8'd1;
        end
      end
      ST_HOLD: begin
        if (tick_s) begin
          state_s   = ST_IDLE;
          ss_s      = 1'b1;
          mosi_s    = 1'b0;
          rx_byte_s = rx_shift_r;
          done_s    = 1'b1;
        end else begin
          hcnt_s = hcnt_r - 8'd1;
        end
      end
      default: begin
        state_s = ST_IDLE;
        ss_s    = 1'b1;
        sclk_s  = 1'b0;
        mosi_s  = 1'b0;
      end
    endcase

    // A DATA write during a transfer is dropped and flagged.
    if (wr_data_s && busy_s) begin
      ovr_s = 1'b1;
    end else begin
      ovr_s = ovr_s;
    end

    // Clearing EN during a transfer abandons it without completing.
    if (wr_ctrl_s && !data_i[0] && busy_s) begin
      state_s   = ST_IDLE;
      ss_s      = 1'b1;
      sclk_s    = 1'b0;
      mosi_s    = 1'b0;
      hcnt_s    = 8'd0;
      ecnt_s    = 4'd0;
      rx_byte_s = rx_byte_r;
      done_s    = done_r;
    end else begin
      rx_byte_s = rx_byte_s;
    end
  end

  // State and register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      ctrl_en_r  <= 1'b0;
      ctrl_div_r <= 8'd0;
      done_r     <= 1'b0;
      ovr_r      <= 1'b0;
      rx_byte_r  <= 8'd0;
      tx_shift_r <= 8'd0;
      rx_shift_r <= 8'd0;
      hcnt_r     <= 8'd0;
      ecnt_r     <= 4'd0;
      sclk_r     <= 1'b0;
      ss_r       <= 1'b1;
      mosi_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      ctrl_en_r  <= ctrl_en_s;
      ctrl_div_r <= ctrl_div_s;
      done_r     <= done_s;
      ovr_r      <= ovr_s;
      rx_byte_r  <= rx_byte_s;
      tx_shift_r <= tx_shift_s;
      rx_shift_r <= rx_shift_s;
      hcnt_r     <= hcnt_s;
      ecnt_r     <= ecnt_s;
      sclk_r     <= sclk_s;
      ss_r       <= ss_s;
      mosi_r     <= mosi_s;
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Directed self-checking bench for spi_master.
module tb_spi_master;

  logic        clk;
  logic        rst;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        spi_clk;
  logic        spi_ss;
  logic        spi_mosi;
  logic        spi_miso;
  logic        loop_mode;
  logic        miso_tie;

  int n_checks = 0;
  int n_errors = 0;

  // Monitor results
  int          m_busy;
  int          m_pulses;
  int          m_high;
  int          m_ss_low;
  logic [7:0]  m_byte;
  logic [31:0] rd;

  assign spi_miso = loop_mode ? spi_mosi : miso_tie;

  spi_master dut (
    .clk      (clk),
    .rst      (rst),
    .we_i     (we_i),
    .addr_i   (addr_i),
    .data_i   (data_i),
    .data_o   (data_o),
    .spi_clk  (spi_clk),
    .spi_ss   (spi_ss),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    addr_i = a;
    data_i = d;
    we_i   = 1'b1;
    @(posedge clk);
    #1;
    we_i   = 1'b0;
    data_i = 32'h0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
    addr_i = a;
    #1;
    d = data_o;
  endtask

  // Follow a transfer until BUSY drops, gathering clock/select/data statistics.
  task automatic watch_transfer();
    logic prev;
    m_busy = 0; m_pulses = 0; m_high = 0; m_ss_low = 0; m_byte = 8'h00;
    prev = spi_clk;
    addr_i = 32'h4;
    #1;
    while (data_o[0] && m_busy < 2000) begin
      m_busy++;
      if (!spi_ss) m_ss_low++;
      if (spi_clk) m_high++;
      if (spi_clk && !prev) begin
        m_pulses++;
        m_byte = {m_byte[6:0], spi_mosi};
      end
      prev = spi_clk;
      @(posedge clk);
      #2;
    end
    if (m_busy >= 2000) check("busy_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
    end
    #1;
  endtask

  initial begin
    rst = 1'b1; we_i = 1'b0; addr_i = 32'h0; data_i = 32'h0;
    loop_mode = 1'b1; miso_tie = 1'b0;
    wait_cycles(3);
    rst = 1'b0;
    wait_cycles(1);

    // Reset state
    check("rst_ss", {31'h0, spi_ss}, 32'h1);
    check("rst_clk", {31'h0, spi_clk}, 32'h0);
    check("rst_mosi", {31'h0, spi_mosi}, 32'h0);
    bus_rd(32'h0, rd); check("rst_ctrl", rd, 32'h0);
    bus_rd(32'h4, rd); check("rst_stat", rd, 32'h0);
    bus_rd(32'h8, rd); check("rst_data", rd, 32'h0);

    // DIV=0 loopback of 0xA5
    bus_wr(32'h0, 32'h0000_0001);
    bus_rd(32'h0, rd); check("ctrl_rb", rd, 32'h0000_0001);
    bus_wr(32'h8, 32'h0000_00A5);
    watch_transfer();
    check("t1_busy", m_busy, 32'd18);
    check("t1_pulses", m_pulses, 32'd8);
    check("t1_high", m_high, 32'd8);
    check("t1_ss_low", m_ss_low, 32'd18);
    check("t1_mosi", {24'h0, m_byte}, 32'hA5);
    check("t1_ss_end", {31'h0, spi_ss}, 32'h1);
    check("t1_mosi_idle", {31'h0, spi_mosi}, 32'h0);
    bus_rd(32'h8, rd); check("t1_data", rd, 32'hA5);
    bus_rd(32'h4, rd); check("t1_stat", rd, 32'h2);

    // DIV=3, miso tied high, 0x3C
    loop_mode = 1'b0; miso_tie = 1'b1;
    bus_wr(32'h0, 32'h0000_0301);
    bus_wr(32'h8, 32'h0000_003C);
    bus_rd(32'h4, rd); check("t2_done_clr", rd, 32'h1);
    watch_transfer();
    check("t2_busy", m_busy, 32'd72);
    check("t2_pulses", m_pulses, 32'd8);
    check("t2_high", m_high, 32'd32);
    check("t2_mosi", {24'h0, m_byte}, 32'h3C);
    bus_rd(32'h8, rd); check("t2_data", rd, 32'hFF);

    // Overrun: second DATA write while busy
    loop_mode = 1'b1;
    bus_wr(32'h0, 32'h0000_0001);
    bus_wr(32'h8, 32'h0000_005A);
    bus_wr(32'h8, 32'h0000_00FF);
    watch_transfer();
    check("t3_busy", m_busy, 32'd17);
    check("t3_mosi", {24'h0, m_byte}, 32'h5A);
    bus_rd(32'h8, rd); check("t3_data", rd, 32'h5A);
    bus_rd(32'h4, rd); check("t3_stat", rd, 32'h6);
    bus_wr(32'h4, 32'h0000_0006);
    bus_rd(32'h4, rd); check("t3_w1c", rd, 32'h0);

    // EN=0: DATA write ignored, no overrun
    bus_wr(32'h0, 32'h0000_0000);
    bus_wr(32'h8, 32'h0000_0077);
    m_ss_low = 0;
    for (int i = 0; i < 20; i++) begin
      if (!spi_ss) m_ss_low++;
      @(posedge clk); #1;
    end
    check("t4_ss_low", m_ss_low, 32'd0);
    bus_rd(32'h4, rd); check("t4_stat", rd, 32'h0);
    bus_rd(32'h8, rd); check("t4_data", rd, 32'h5A);

    // Unmapped offset and CTRL reserved bits
    bus_wr(32'h0C, 32'hFFFF_FFFF);
    bus_rd(32'h0C, rd); check("unmapped", rd, 32'h0);
    bus_wr(32'h0, 32'hFFFF_FFFE);
    bus_rd(32'h0, rd); check("ctrl_mask", rd, 32'h0000_FF00);

    // Abort after the third rising spi_clk (DIV=1)
    bus_wr(32'h0, 32'h0000_0101);
    bus_wr(32'h8, 32'h0000_0081);
    begin
      int rises = 0;
      int guard = 0;
      logic prev = 1'b0;
      while (rises < 3 && guard < 500) begin
        if (spi_clk && !prev) rises++;
        prev = spi_clk;
        if (rises < 3) begin
          @(posedge clk); #1;
        end
        guard++;
      end
      if (guard >= 500) check("abort_timeout", 32'd1, 32'd0);
    end
    bus_wr(32'h0, 32'h0000_0100);
    check("t5_ss", {31'h0, spi_ss}, 32'h1);
    check("t5_clk", {31'h0, spi_clk}, 32'h0);
    check("t5_mosi", {31'h0, spi_mosi}, 32'h0);
    bus_rd(32'h4, rd); check("t5_stat", rd, 32'h0);
    bus_rd(32'h8, rd); check("t5_data", rd, 32'h5A);
    wait_cycles(10);
    check("t5_ss_stay", {31'h0, spi_ss}, 32'h1);

    // Reset mid-SHIFT
    bus_wr(32'h0, 32'h0000_0201);
    bus_wr(32'h8, 32'h0000_00C3);
    wait_cycles(10);
    bus_rd(32'h4, rd); check("t6_busy_pre", rd, 32'h1);
    rst = 1'b1;
    wait_cycles(1);
    check("t6_ss", {31'h0, spi_ss}, 32'h1);
    check("t6_clk", {31'h0, spi_clk}, 32'h0);
    check("t6_mosi", {31'h0, spi_mosi}, 32'h0);
    bus_rd(32'h0, rd); check("t6_ctrl", rd, 32'h0);
    bus_rd(32'h4, rd); check("t6_stat", rd, 32'h0);
    bus_rd(32'h8, rd); check("t6_data", rd, 32'h0);
    rst = 1'b0;
    wait_cycles(5);
    check("t6_ss_after", {31'h0, spi_ss}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL provide: clk  input  1  system clock; all logic on rising edge.
REQ-002 SHALL provide: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL provide: we_i  input  1  bus write strobe from RIB slave-5 port.
REQ-004 SHALL provide: addr_i  input  32  bus address; only addr_i[7:0] decoded.
REQ-005 SHALL provide: data_i  input  32  bus write data.
REQ-006 SHALL provide: data_o  output  32  bus read data, combinational from addr_i.
REQ-007 SHALL provide: spi_clk  output  1  SPI serial clock (mode 0).
REQ-008 SHALL provide: spi_ss  output  1  slave select, active-low.
REQ-009 SHALL provide: spi_mosi  output  1  serial data out, MSB first.
REQ-010 SHALL provide: spi_miso  input  1  serial data in.

Function
REQ-011 SHALL decode offsets: 0x00 CTRL (RW), 0x04 STATUS (R, W1C), 0x08 DATA (W=TX start, R=RX); other offsets read 0, writes ignored.
REQ-012 SHALL define CTRL: bit0 EN, bits[15:8] DIV; other bits read 0.
REQ-013 SHALL define STATUS: bit0 BUSY, bit1 DONE (sticky), bit2 OVR (sticky); bits[31:3] read 0.
REQ-014 SHALL read DATA as {24'h0, rx_byte}; rx_byte holds last completed received byte.
REQ-015 SHALL use half-period h = DIV+1 clk cycles (DIV=0 -> h=1, DIV=255 -> h=256).
REQ-016 SHALL implement FSM IDLE -> SETUP -> SHIFT -> HOLD -> IDLE with 8-bit half-period counter and 4-bit edge counter.
REQ-017 SHALL start a transfer only when state=IDLE, EN=1, we_i=1, offset 0x08: load data_i[7:0] into tx shift register, clear DONE, enter SETUP at that edge.
REQ-018 SHALL, in SETUP: spi_ss=0, spi_clk=0, spi_mosi=tx bit7; after h cycles enter SHIFT.
REQ-019 SHALL, in SHIFT: toggle spi_clk every h cycles, 16 toggles total; on each rising toggle sample spi_miso into rx shift LSB; on each falling toggle except the last shift tx left so spi_mosi presents next bit.
REQ-020 SHALL, after 16th toggle (spi_clk low), enter HOLD for h cycles with spi_ss=0, then return to IDLE: spi_ss=1, rx_byte<=rx shift, DONE=1.
REQ-021 SHALL give total latency 18h cycles from accepting edge to BUSY=0; BUSY=1 in SETUP/SHIFT/HOLD.
REQ-022 SHALL ignore DATA writes while BUSY and set OVR; ignore DATA writes when EN=0 (no OVR).
REQ-023 SHALL clear DONE/OVR on STATUS write with corresponding data_i bit 1; set takes priority over clear in the same cycle.
REQ-024 SHALL, on CTRL write with EN=0 while BUSY, abort at that edge: state IDLE, spi_ss=1, spi_clk=0, spi_mosi=0, rx_byte unchanged, DONE not set.
REQ-025 SHALL apply CTRL DIV changes mid-transfer only from the next half-period count reload.
REQ-026 SHALL hold spi_mosi=0 in IDLE; spi_clk idles low.

Reset
REQ-027 SHALL, on rst=1 at rising clk edge (including mid-transfer): state IDLE, CTRL=0, STATUS=0, rx_byte=0, shift registers 0, spi_clk=0, spi_ss=1, spi_mosi=0.
REQ-028 SHALL keep data_o combinational, reflecting reset register values (0) in the cycle after reset.

Verification
REQ-029 SHALL test: CTRL=0x0000_0001 (DIV=0), write DATA=0xA5, spi_miso looped to spi_mosi -> BUSY for 18 cycles, 8 spi_clk pulses, mosi 1,0,1,0,0,1,0,1, DATA reads 0xA5, DONE=1.
REQ-030 SHALL test: DIV=3 (h=4), write 0x3C, miso tied 1 -> transfer 72 cycles, spi_clk high/low 4 cycles each, DATA reads 0xFF.
REQ-031 SHALL test: second DATA write during BUSY -> OVR=1, in-flight byte unaffected; write STATUS=0x6 -> DONE=OVR=0.
REQ-032 SHALL test: EN=0 then DATA write -> no transfer, spi_ss stays 1, OVR=0.
REQ-033 SHALL test: CTRL write EN=0 after 3rd rising spi_clk -> next cycle spi_ss=1, BUSY=0, DONE=0, rx_byte unchanged.
REQ-034 SHALL test: rst asserted mid-SHIFT -> next edge all outputs/registers at REQ-027 values; reads of 0x00/0x04/0x08 return 0.
